// File: rtl/alu_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_scheduler
// Purpose  : Two-requester round-robin scheduler in front of one shared
//            combinational 8-bit ALU. A granted request has its operands
//            registered onto the ALU inputs. The ALU result is then captured
//            into a single tagged response channel. Divide-by-zero gets a
//            defined result plus an error flag. Carry is masked for non-add ops.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            req_valid/ready[1:0]        - per-requester handshake
//            req_a/req_b[15:0]           - {req1, req0} 8-bit operands
//            req_op[7:0]                 - {req1, req0} 4-bit opcodes
//            alu_operand_a/b, alu_operation - registered ALU inputs
//            alu_result, alu_carry_out   - ALU combinational outputs
//            rsp_valid/ready, rsp_id, rsp_data, rsp_carry, rsp_err
//            busy                        - high when not IDLE
//            stat_cnt0/1                 - completion counters
// Config   : define ALU_SCHED_STATS_EN to build saturating per-requester
//            completion counters. Otherwise stat_cnt0/1 read 0.
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_scheduler #(
  parameter logic [7:0] DIV_ZERO_RESULT = 8'hFF,
  parameter int         STAT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [15:0]       req_a,
  input  logic [15:0]       req_b,
  input  logic [7:0]        req_op,
  output logic [7:0]        alu_operand_a,
  output logic [7:0]        alu_operand_b,
  output logic [3:0]        alu_operation,
  input  logic [7:0]        alu_result,
  input  logic              alu_carry_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [7:0]        rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy,
  output logic [STAT_W-1:0] stat_cnt0,
  output logic [STAT_W-1:0] stat_cnt1
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant_id;
  logic   grant_any;
  logic   handshake;
  logic   div_zero;

  // Round-robin pick. On a tie, the requester that did not win last time gets the grant.
  always_comb begin
    grant_any = |req_valid;
    case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  assign handshake = (state == IDLE) && grant_any;

  // rst_n gates ready so that nothing is accepted while reset is asserted.
  always_comb begin
    req_ready = 2'b00;
    if (handshake && rst_n) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign div_zero = (alu_operation == OP_DIV) && (alu_operand_b == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= 1'b1;
      alu_operand_a <= 8'd0;
      alu_operand_b <= 8'd0;
      alu_operation <= 4'd0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_data      <= 8'd0;
      rsp_carry     <= 1'b0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            alu_operand_a <= grant_id ? req_a[15:8] : req_a[7:0];
            alu_operand_b <= grant_id ? req_b[15:8] : req_b[7:0];
            alu_operation <= grant_id ? req_op[7:4] : req_op[3:0];
            rsp_id        <= grant_id;
            last_grant    <= grant_id;
          end
        end
        EXEC: begin
          // The ALU inputs have been stable for a full cycle, so sample now.
          rsp_data  <= div_zero ? DIV_ZERO_RESULT : alu_result;
          rsp_err   <= div_zero;
          rsp_carry <= (alu_operation == OP_ADD) ? alu_carry_out : 1'b0;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SCHED_STATS_EN
  logic rsp_fire;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (rsp_fire) begin
      if (!rsp_id && (stat_cnt0 != {STAT_W{1'b1}})) stat_cnt0 <= stat_cnt0 + 1'b1;
      if ( rsp_id && (stat_cnt1 != {STAT_W{1'b1}})) stat_cnt1 <= stat_cnt1 + 1'b1;
    end
  end
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_scheduler
// Purpose  : Self-checking bench for alu_req_scheduler. It uses a behavioural ALU,
//            directed vectors and a queue-based response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [7:0]  req_op = '0;
  logic [7:0]  alu_operand_a, alu_operand_b;
  logic [3:0]  alu_operation;
  logic [7:0]  alu_result;
  logic        alu_carry_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_carry, rsp_err, busy;
  logic [15:0] stat_cnt0, stat_cnt1;

  alu_req_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy), .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
  );

  always #5 clk = ~clk;

  // Behavioural ALU. Non-add ops drive carry high so that the masking is visible.
  // Divide-by-zero returns junk so that the replacement is visible.
  always_comb begin
    alu_result    = alu_operand_a ^ alu_operand_b;
    alu_carry_out = 1'b1;
    case (alu_operation)
      4'b0000: {alu_carry_out, alu_result} = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
      4'b0001: alu_result = alu_operand_a - alu_operand_b;
      4'b0010: alu_result = alu_operand_a & alu_operand_b;
      4'b0011: alu_result = (alu_operand_b == 8'd0) ? 8'h5A : alu_operand_a / alu_operand_b;
      default: ;
    endcase
  end

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       carry;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_total  = 0;
  int   n_passed = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard monitor: one pop per response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id",    {31'd0, rsp_id},    {31'd0, e.id});
          check("rsp_data",  {24'd0, rsp_data},  {24'd0, e.data});
          check("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.carry});
          check("rsp_err",   {31'd0, rsp_err},   {31'd0, e.err});
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    check("drain_timeout", exp_q.size(), 32'd0);
  endtask

  task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic [7:0] ed, input logic ec,
                       input logic ee, input bit chk_lat);
    bit got;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    req_a[id*8 +: 8]  = a;
    req_b[id*8 +: 8]  = b;
    req_op[id*4 +: 4] = op;
    req_valid[id]     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      req_valid[id] = 1'b0;
    end else begin
      e.id = id[0]; e.data = ed; e.carry = ec; e.err = ee;
      exp_q.push_back(e);
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
      if (chk_lat) begin
        @(negedge clk);
        check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("exec_busy",      {31'd0, busy},      32'd1);
        @(negedge clk);
        check("lat2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      end
    end
  endtask

  // Directed vectors: id, a, b, op, expected data, carry, err
  localparam int NV = 7;
  int         v_id  [NV] = '{0, 1, 1, 0, 1, 0, 1};
  logic [7:0] v_a   [NV] = '{8'd200, 8'd9, 8'd9, 8'd50, 8'hF0, 8'h0F, 8'd1};
  logic [7:0] v_b   [NV] = '{8'd100, 8'd0, 8'd2, 8'd20, 8'h3C, 8'hFF, 8'd2};
  logic [3:0] v_op  [NV] = '{4'h0, 4'h3, 4'h3, 4'h1, 4'h2, 4'hF, 4'h0};
  logic [7:0] v_d   [NV] = '{8'd44, 8'hFF, 8'd4, 8'd30, 8'h30, 8'hF0, 8'd3};
  logic       v_c   [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       v_e   [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    exp_t e;
    int   n;
    int   last;
    bit   seen;

    // Reset state: ready must be held low even with both requesters valid.
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_alu_a",     {24'd0, alu_operand_a}, 32'd0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-op vectors, including divide-by-zero and the carry masking.
    for (int i = 0; i < NV; i++) begin
      do_op(v_id[i], v_a[i], v_b[i], v_op[i], v_d[i], v_c[i], v_e[i], i == 0);
      drain();
    end

    // Fairness: both requesters are valid continuously after reset.
    do_reset();
    req_a = {8'd250, 8'd10};
    req_b = {8'd10, 8'd5};
    req_op = 8'h00;
    for (int i = 0; i < 6; i++) begin
      e.id = i[0]; e.carry = i[0]; e.err = 1'b0;
      e.data = i[0] ? 8'd4 : 8'd15;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 2'b11;
    n = 0; last = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        check("grant_order", {30'd0, req_ready}, (n % 2 == 0) ? 32'd1 : 32'd2);
        if (n > 0) check("op_spacing", cyc - last, 32'd3);
        last = cyc;
        n++;
        if (n == 6) begin
          @(posedge clk);
          #1 req_valid = 2'b00;
        end
      end
      if (n < 6) @(negedge clk);
    end
    check("fair_timeout", n, 32'd6);
    req_valid = 2'b00;
    drain();

    // Back-pressure: the response is held while requester 1 waits.
    rsp_ready = 1'b0;
    do_op(0, 8'd3, 8'd4, 4'h0, 8'd7, 1'b0, 1'b0, 1'b0);
    req_a[15:8] = 8'd1; req_b[15:8] = 8'd1; req_op[7:4] = 4'h3;
    req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("stall_rsp_seen", {31'd0, seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_data",  {24'd0, rsp_data},  32'd7);
      check("stall_req_ready", {30'd0, req_ready}, 32'd0);
      check("stall_busy",      {31'd0, busy},      32'd1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);     // the monitor pops the held response here
    @(negedge clk);
    #1;
    check("post_accept_busy",  {31'd0, busy},      32'd0);
    check("post_accept_ready", {30'd0, req_ready}, 32'd2);
    e.id = 1'b1; e.data = 8'd1; e.carry = 1'b0; e.err = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    drain();

    // Reset during EXEC: the op is discarded and requester 0 wins next.
    @(negedge clk);
    req_a[7:0] = 8'd5; req_b[7:0] = 8'd5; req_op[3:0] = 4'h0;
    req_valid = 2'b01;
    #1;
    check("midrst_ready0", {30'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid},     32'd0);
    check("midrst_busy",      {31'd0, busy},          32'd0);
    check("midrst_req_ready", {30'd0, req_ready},     32'd0);
    check("midrst_alu_a",     {24'd0, alu_operand_a}, 32'd0);
    check("midrst_alu_op",    {28'd0, alu_operation}, 32'd0);
    check("midrst_rsp_data",  {24'd0, rsp_data},      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_next_grant", {30'd0, req_ready}, 32'd1);
    e.id = 1'b0; e.data = 8'd10; e.carry = 1'b0; e.err = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 2'b00;
    drain();

    // Completion counters.
    do_reset();
    #1;
    check("stat0_rst", {16'd0, stat_cnt0}, 32'd0);
    check("stat1_rst", {16'd0, stat_cnt1}, 32'd0);
    do_op(0, 8'd1, 8'd1, 4'h0, 8'd2, 1'b0, 1'b0, 1'b0); drain();
    do_op(1, 8'd2, 8'd2, 4'h0, 8'd4, 1'b0, 1'b0, 1'b0); drain();
    do_op(0, 8'd3, 8'd3, 4'h0, 8'd6, 1'b0, 1'b0, 1'b0); drain();
    do_op(1, 8'd4, 8'd4, 4'h0, 8'd8, 1'b0, 1'b0, 1'b0); drain();
    do_op(0, 8'd5, 8'd5, 4'h0, 8'd10, 1'b0, 1'b0, 1'b0); drain();
    @(negedge clk);
`ifdef ALU_SCHED_STATS_EN
    check("stat_cnt0", {16'd0, stat_cnt0}, 32'd3);
    check("stat_cnt1", {16'd0, stat_cnt1}, 32'd2);
`else
    check("stat_cnt0", {16'd0, stat_cnt0}, 32'd0);
    check("stat_cnt1", {16'd0, stat_cnt1}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
